// File: rtl/colour_bbox_overlay_pkg.sv
// ---------------------------------------------------------------------------
// colour_bbox_overlay_pkg
// Shared definitions for the colour bounding-box overlay block:
//   - Avalon-ST Video packet-type code for video data packets
//   - FSM state encodings (plain localparams so legacy code can reuse them)
//   - coordinate / count widths
//   - RGB pixel layout {B,G,R} and the colour threshold helper
// No ports; imported by colour_bbox_overlay and its bbox_accum sub-module.
// ---------------------------------------------------------------------------
package colour_bbox_overlay_pkg;

  // Low nibble of a packet-type (sop) beat; anything else is a control packet
  localparam logic [3:0] PKT_VIDEO = 4'h0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CTRL  = 2'd1;
  localparam logic [1:0] ST_VIDEO = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam int COORD_W = 12;
  localparam int CNT_W   = 21;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pixel_t;

  // Unsigned 8-bit threshold: strong red, weak green and blue
  function automatic logic colour_match(input pixel_t p,
                                        input logic [7:0] r_min,
                                        input logic [7:0] g_max,
                                        input logic [7:0] b_max);
    return (p.r >= r_min) && (p.g <= g_max) && (p.b <= b_max);
  endfunction

endpackage

// File: rtl/colour_bbox_overlay_bbox_accum.sv
// ---------------------------------------------------------------------------
// colour_bbox_overlay_bbox_accum
// Running min/max/count accumulators for matched pixels, plus the per-frame
// latched result registers read by the control processor.
// Ports:
//   clk, reset_n          stream clock, async active-low reset
//   clear                 start of a video frame: reset accumulators
//   update                current pixel (x,y) matched the colour threshold
//   latch                 frame completed cleanly: publish results
//   x, y                  current pixel coordinate
//   bbox_x_min..y_max     latched box (all 0 when no pixel matched)
//   bbox_count            latched matched-pixel count (saturating)
//   bbox_valid            latched bbox_count >= MIN_PIX
// ---------------------------------------------------------------------------
module colour_bbox_overlay_bbox_accum
  import colour_bbox_overlay_pkg::*;
#(
  parameter int MIN_PIX = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               update,
  input  logic               latch,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] bbox_x_min,
  output logic [COORD_W-1:0] bbox_x_max,
  output logic [COORD_W-1:0] bbox_y_min,
  output logic [COORD_W-1:0] bbox_y_max,
  output logic [CNT_W-1:0]   bbox_count,
  output logic               bbox_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] MIN_PIX_C = CNT_W'(MIN_PIX);

  logic [COORD_W-1:0] acc_x_min, acc_x_max, acc_y_min, acc_y_max;
  logic [CNT_W-1:0]   acc_cnt;
  logic [COORD_W-1:0] nxt_x_min, nxt_x_max, nxt_y_min, nxt_y_max;
  logic [CNT_W-1:0]   nxt_cnt;

  // Next accumulator values. The latch path uses these (not the registers)
  // so that a match on the frame's final pixel is included in the result.
  always_comb begin
    nxt_x_min = acc_x_min;
    nxt_x_max = acc_x_max;
    nxt_y_min = acc_y_min;
    nxt_y_max = acc_y_max;
    nxt_cnt   = acc_cnt;
    if (clear) begin
      nxt_x_min = '1;
      nxt_x_max = '0;
      nxt_y_min = '1;
      nxt_y_max = '0;
      nxt_cnt   = '0;
    end else if (update) begin
      if (x < acc_x_min) nxt_x_min = x;
      if (x > acc_x_max) nxt_x_max = x;
      if (y < acc_y_min) nxt_y_min = y;
      if (y > acc_y_max) nxt_y_max = y;
      if (acc_cnt != CNT_MAX) nxt_cnt = acc_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_x_min <= '0;
      acc_x_max <= '0;
      acc_y_min <= '0;
      acc_y_max <= '0;
      acc_cnt   <= '0;
    end else begin
      acc_x_min <= nxt_x_min;
      acc_x_max <= nxt_x_max;
      acc_y_min <= nxt_y_min;
      acc_y_max <= nxt_y_max;
      acc_cnt   <= nxt_cnt;
    end
  end

  // An empty frame publishes zero coordinates rather than the FFF/0 seeds
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bbox_x_min <= '0;
      bbox_x_max <= '0;
      bbox_y_min <= '0;
      bbox_y_max <= '0;
      bbox_count <= '0;
      bbox_valid <= 1'b0;
    end else if (latch) begin
      bbox_count <= nxt_cnt;
      if (nxt_cnt == '0) begin
        bbox_x_min <= '0;
        bbox_x_max <= '0;
        bbox_y_min <= '0;
        bbox_y_max <= '0;
        bbox_valid <= 1'b0;
      end else begin
        bbox_x_min <= nxt_x_min;
        bbox_x_max <= nxt_x_max;
        bbox_y_min <= nxt_y_min;
        bbox_y_max <= nxt_y_max;
        bbox_valid <= (nxt_cnt >= MIN_PIX_C);
      end
    end
  end

endmodule

// File: rtl/colour_bbox_overlay.sv
// ---------------------------------------------------------------------------
// colour_bbox_overlay
// Avalon-ST Video pass-through (24b RGB, ready latency 1, zero latency) that
// measures the bounding box and pixel count of colour-matched pixels in each
// frame and optionally draws the previous frame's box onto the stream.
// Ports:
//   clk, reset_n                 stream clock, async active-low reset
//   sink_data/valid/sop/eop      upstream video, data = {B,G,R}
//   sink_ready                   = source_ready
//   source_data/valid/sop/eop    downstream video (data may be overlaid)
//   source_ready                 downstream ready
//   overlay_en                   draw latched box (sampled per beat)
//   bbox_x_min/x_max/y_min/y_max latched box of last good frame
//   bbox_count, bbox_valid       latched count and count >= MIN_PIX
//   result_strobe                1-cycle pulse when results update
//   frame_err                    1-cycle pulse on a malformed packet
// ---------------------------------------------------------------------------
module colour_bbox_overlay
  import colour_bbox_overlay_pkg::*;
#(
  parameter int          VIDEO_W    = 1280,
  parameter int          VIDEO_H    = 720,
  parameter logic [7:0]  R_MIN      = 8'd160,
  parameter logic [7:0]  G_MAX      = 8'd90,
  parameter logic [7:0]  B_MAX      = 8'd90,
  parameter int          MIN_PIX    = 64,
  parameter logic [23:0] BOX_COLOUR = 24'h00FF00
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [23:0]        sink_data,
  input  logic               sink_valid,
  input  logic               sink_sop,
  input  logic               sink_eop,
  output logic               sink_ready,
  output logic [23:0]        source_data,
  output logic               source_valid,
  output logic               source_sop,
  output logic               source_eop,
  input  logic               source_ready,
  input  logic               overlay_en,
  output logic [COORD_W-1:0] bbox_x_min,
  output logic [COORD_W-1:0] bbox_x_max,
  output logic [COORD_W-1:0] bbox_y_min,
  output logic [COORD_W-1:0] bbox_y_max,
  output logic [CNT_W-1:0]   bbox_count,
  output logic               bbox_valid,
  output logic               result_strobe,
  output logic               frame_err
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(VIDEO_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(VIDEO_H - 1);

  logic [1:0]         state, state_nxt;
  logic [COORD_W-1:0] x, y;
  logic               pixel_beat, video_sop, frame_end, is_match;
  logic               strobe_nxt, err_nxt;
  logic               on_col, on_row, overlay_hit;

  // Ready latency 1 means every valid beat is accepted, so the stream
  // control signals are pure wires.
  assign sink_ready   = source_ready;
  assign source_valid = sink_valid;
  assign source_sop   = sink_sop;
  assign source_eop   = sink_eop;

  assign video_sop  = sink_valid && sink_sop && (sink_data[3:0] == PKT_VIDEO);
  assign pixel_beat = sink_valid && !sink_sop && (state == ST_VIDEO);
  assign frame_end  = pixel_beat && (x == X_LAST) && (y == Y_LAST);
  assign is_match   = colour_match(pixel_t'(sink_data), R_MIN, G_MAX, B_MAX);

  // Packet FSM. A sop beat always restarts packet classification, even
  // mid-packet, so a lost eop costs only one flagged packet.
  always_comb begin
    state_nxt  = state;
    strobe_nxt = 1'b0;
    err_nxt    = 1'b0;
    if (sink_valid) begin
      if (sink_sop) begin
        err_nxt   = (state != ST_IDLE);
        state_nxt = video_sop ? ST_VIDEO : ST_CTRL;
      end else begin
        case (state)
          ST_CTRL: if (sink_eop) state_nxt = ST_IDLE;
          ST_VIDEO: begin
            if (frame_end) begin
              if (sink_eop) begin
                strobe_nxt = 1'b1;
                state_nxt  = ST_IDLE;
              end else begin
                state_nxt  = ST_DRAIN;
              end
            end else if (sink_eop) begin
              err_nxt   = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
          ST_DRAIN: begin
            if (sink_eop) begin
              err_nxt   = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      result_strobe <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state         <= state_nxt;
      result_strobe <= strobe_nxt;
      frame_err     <= err_nxt;
    end
  end

  // Raster position of the current pixel beat; gaps in valid hold it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (video_sop || frame_end) begin
      x <= '0;
      y <= '0;
    end else if (pixel_beat) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  colour_bbox_overlay_bbox_accum #(
    .MIN_PIX (MIN_PIX)
  ) u_accum (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (video_sop),
    .update     (pixel_beat && is_match),
    .latch      (frame_end && sink_eop),
    .x          (x),
    .y          (y),
    .bbox_x_min (bbox_x_min),
    .bbox_x_max (bbox_x_max),
    .bbox_y_min (bbox_y_min),
    .bbox_y_max (bbox_y_max),
    .bbox_count (bbox_count),
    .bbox_valid (bbox_valid)
  );

  // Box outline drawn from the latched (previous frame) result; a latch on
  // this frame's last beat only takes effect from the next frame.
  assign on_col = ((x == bbox_x_min) || (x == bbox_x_max)) &&
                  (y >= bbox_y_min) && (y <= bbox_y_max);
  assign on_row = ((y == bbox_y_min) || (y == bbox_y_max)) &&
                  (x >= bbox_x_min) && (x <= bbox_x_max);
  assign overlay_hit = overlay_en && bbox_valid && pixel_beat && (on_col || on_row);

  assign source_data = overlay_hit ? BOX_COLOUR : sink_data;

endmodule

// File: tb/tb_colour_bbox_overlay.sv
// ---------------------------------------------------------------------------
// tb_colour_bbox_overlay
// Self-checking bench for colour_bbox_overlay with an 8x4 frame and
// MIN_PIX=2. A behavioural model computes each frame's expected box from
// the pixel array and the expected overlaid stream from the box of the
// previous good frame.
// ---------------------------------------------------------------------------
module tb_colour_bbox_overlay;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam logic [23:0] GREY = 24'h808080;
  localparam logic [23:0] BOXC = 24'h00FF00;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] sink_data;
  logic        sink_valid, sink_sop, sink_eop, sink_ready;
  logic [23:0] source_data;
  logic        source_valid, source_sop, source_eop, source_ready;
  logic        overlay_en;
  logic [11:0] bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
  logic [20:0] bbox_count;
  logic        bbox_valid, result_strobe, frame_err;

  always #5 clk = ~clk;

  colour_bbox_overlay #(
    .VIDEO_W (W),
    .VIDEO_H (H),
    .MIN_PIX (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sink_data     (sink_data),
    .sink_valid    (sink_valid),
    .sink_sop      (sink_sop),
    .sink_eop      (sink_eop),
    .sink_ready    (sink_ready),
    .source_data   (source_data),
    .source_valid  (source_valid),
    .source_sop    (source_sop),
    .source_eop    (source_eop),
    .source_ready  (source_ready),
    .overlay_en    (overlay_en),
    .bbox_x_min    (bbox_x_min),
    .bbox_x_max    (bbox_x_max),
    .bbox_y_min    (bbox_y_min),
    .bbox_y_max    (bbox_y_max),
    .bbox_count    (bbox_count),
    .bbox_valid    (bbox_valid),
    .result_strobe (result_strobe),
    .frame_err     (frame_err)
  );

  int total = 0;
  int bad   = 0;
  int strobe_seen, err_seen;

  logic [23:0] frame_pix [0:39];
  logic [23:0] obs       [0:39];
  logic [23:0] exp_px    [0:31];
  logic [23:0] sop_drv, sop_obs;

  // Model of the latched results
  logic [11:0] m_xmin, m_xmax, m_ymin, m_ymax;
  logic [20:0] m_cnt;
  logic        m_valid;

  function automatic bit is_match(input logic [23:0] p);
    return (p[7:0] >= 8'd160) && (p[15:8] <= 8'd90) && (p[23:16] <= 8'd90);
  endfunction

  function automatic logic [69:0] dut_res();
    return {bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, bbox_count, bbox_valid};
  endfunction

  function automatic logic [69:0] model_res();
    return {m_xmin, m_xmax, m_ymin, m_ymax, m_cnt, m_valid};
  endfunction

  task automatic model_clear();
    m_xmin = '0; m_xmax = '0; m_ymin = '0; m_ymax = '0; m_cnt = '0; m_valid = 1'b0;
  endtask

  // Expected outgoing pixels for the frame in frame_pix using the current box
  task automatic model_expect(input bit en);
    for (int i = 0; i < NPIX; i++) begin
      int  px, py;
      bit  col, row;
      px  = i % W;
      py  = i / W;
      col = (px == int'(m_xmin) || px == int'(m_xmax)) && py >= int'(m_ymin) && py <= int'(m_ymax);
      row = (py == int'(m_ymin) || py == int'(m_ymax)) && px >= int'(m_xmin) && px <= int'(m_xmax);
      exp_px[i] = (en && m_valid && (col || row)) ? BOXC : frame_pix[i];
    end
  endtask

  // Box of a complete frame
  task automatic model_latch();
    int xmn, xmx, ymn, ymx, cnt;
    xmn = 4095; xmx = 0; ymn = 4095; ymx = 0; cnt = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (is_match(frame_pix[i])) begin
        cnt++;
        if (i % W < xmn) xmn = i % W;
        if (i % W > xmx) xmx = i % W;
        if (i / W < ymn) ymn = i / W;
        if (i / W > ymx) ymx = i / W;
      end
    end
    if (cnt == 0) model_clear();
    else begin
      m_xmin = 12'(xmn); m_xmax = 12'(xmx); m_ymin = 12'(ymn); m_ymax = 12'(ymx);
      m_cnt = 21'(cnt); m_valid = (cnt >= 2);
    end
  endtask

  task automatic fill_const(input logic [23:0] c);
    for (int i = 0; i < 40; i++) frame_pix[i] = c;
  endtask

  task automatic fill_random(input int pct);
    logic [31:0] r;
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      if (int'($urandom_range(99)) < pct)
        frame_pix[i] = {8'($urandom_range(0, 90)), 8'($urandom_range(0, 90)), 8'($urandom_range(160, 255))};
      else
        frame_pix[i] = r[23:0];
    end
  endtask

  task automatic drive_beat(input logic [23:0] d, input logic sop, input logic eop,
                            output logic [23:0] out);
    @(negedge clk);
    sink_data  = d;
    sink_valid = 1'b1;
    sink_sop   = sop;
    sink_eop   = eop;
    #1 out = source_data;
    @(posedge clk);
    #1;
    if (result_strobe) strobe_seen++;
    if (frame_err)     err_seen++;
  endtask

  task automatic idle_cycles(input int n);
    logic [31:0] r;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      r = $urandom;
      sink_valid = 1'b0;
      sink_sop   = 1'b0;
      sink_eop   = 1'b0;
      sink_data  = r[23:0];
      @(posedge clk);
      #1;
      if (result_strobe) strobe_seen++;
      if (frame_err)     err_seen++;
    end
  endtask

  task automatic send_frame(input bit en, input int gap_pct, input int n_pix, input bit eop_last);
    logic [31:0] r;
    r = $urandom;
    sop_drv = {r[23:4], 4'h0};
    overlay_en = en;
    drive_beat(sop_drv, 1'b1, 1'b0, sop_obs);
    for (int i = 0; i < n_pix; i++) begin
      if (int'($urandom_range(99)) < gap_pct) idle_cycles(int'($urandom_range(1, 3)));
      drive_beat(frame_pix[i], 1'b0, eop_last && (i == n_pix - 1), obs[i]);
    end
    idle_cycles(1);
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    logic [23:0] dummy;
    reset_n = 1'b0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    sink_data = '0; source_ready = 1'b1; overlay_en = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    total++; if (dut_res() !== 70'd0) begin bad++; $display("[TB] FAIL reset_results got=%h want=0", dut_res()); end
    total++; if (result_strobe !== 1'b0) begin bad++; $display("[TB] FAIL reset_strobe got=%b want=0", result_strobe); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b want=0", frame_err); end
    @(negedge clk) reset_n = 1'b1;
    // partial red frame, then reset mid-frame
    fill_const(24'h0000FF);
    drive_beat(24'h000000, 1'b1, 1'b0, dummy);
    for (int i = 0; i < 10; i++) drive_beat(frame_pix[i], 1'b0, 1'b0, dummy);
    @(negedge clk);
    sink_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    total++; if (dut_res() !== 70'd0) begin bad++; $display("[TB] FAIL midreset_results got=%h want=0", dut_res()); end
    @(negedge clk) reset_n = 1'b1;
    strobe_seen = 0; err_seen = 0;
    fill_const(GREY);
    model_expect(1'b0);
    send_frame(1'b0, 0, NPIX, 1'b1);
    model_latch();
    total++; if (strobe_seen !== 1) begin bad++; $display("[TB] FAIL grey_strobe got=%0d want=1", strobe_seen); end
    total++; if (err_seen !== 0) begin bad++; $display("[TB] FAIL grey_err got=%0d want=0", err_seen); end
    total++; if (dut_res() !== 70'd0) begin bad++; $display("[TB] FAIL grey_results got=%h want=0", dut_res()); end
    for (int i = 0; i < NPIX; i++) begin
      total++; if (obs[i] !== exp_px[i]) begin bad++; $display("[TB] FAIL grey_pass[%0d] got=%h want=%h", i, obs[i], exp_px[i]); end
    end
  endtask

  task automatic test_red_box();
    strobe_seen = 0; err_seen = 0;
    fill_const(GREY);
    frame_pix[1*W + 2] = 24'h0000FF;
    frame_pix[2*W + 5] = 24'h0000FF;
    model_expect(1'b1);
    send_frame(1'b1, 0, NPIX, 1'b1);
    total++; if (dut_res() !== {12'd2, 12'd5, 12'd1, 12'd2, 21'd2, 1'b1}) begin
      bad++; $display("[TB] FAIL red_box got=%h want=%h", dut_res(), {12'd2, 12'd5, 12'd1, 12'd2, 21'd2, 1'b1}); end
    total++; if (strobe_seen !== 1) begin bad++; $display("[TB] FAIL red_strobe got=%0d want=1", strobe_seen); end
    for (int i = 0; i < NPIX; i++) begin
      total++; if (obs[i] !== exp_px[i]) begin bad++; $display("[TB] FAIL red_pass[%0d] got=%h want=%h", i, obs[i], exp_px[i]); end
    end
    model_latch();
  endtask

  task automatic test_overlay();
    int boxed;
    strobe_seen = 0; err_seen = 0;
    fill_const(GREY);
    model_expect(1'b1);
    send_frame(1'b1, 0, NPIX, 1'b1);
    boxed = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (obs[i] === BOXC) boxed++;
      total++; if (obs[i] !== exp_px[i]) begin bad++; $display("[TB] FAIL overlay[%0d] got=%h want=%h", i, obs[i], exp_px[i]); end
    end
    total++; if (boxed !== 8) begin bad++; $display("[TB] FAIL overlay_count got=%0d want=8", boxed); end
    total++; if (sop_obs !== sop_drv) begin bad++; $display("[TB] FAIL overlay_sop got=%h want=%h", sop_obs, sop_drv); end
    model_latch();
  endtask

  task automatic test_threshold_edges();
    strobe_seen = 0; err_seen = 0;
    fill_const(GREY);
    frame_pix[0*W + 1] = {8'd90, 8'd90, 8'd160};
    frame_pix[3*W + 6] = {8'd90, 8'd91, 8'd160};
    frame_pix[0*W + 7] = {8'd90, 8'd90, 8'd159};
    frame_pix[2*W + 3] = {8'd91, 8'd90, 8'd255};
    send_frame(1'b0, 0, NPIX, 1'b1);
    total++; if (dut_res() !== {12'd1, 12'd1, 12'd0, 12'd0, 21'd1, 1'b0}) begin
      bad++; $display("[TB] FAIL edges got=%h want=%h", dut_res(), {12'd1, 12'd1, 12'd0, 12'd0, 21'd1, 1'b0}); end
    model_latch();
  endtask

  task automatic test_short_frame();
    strobe_seen = 0; err_seen = 0;
    fill_const(GREY);
    frame_pix[0*W + 1] = 24'h0000FF;
    frame_pix[3*W + 6] = 24'h0000FF;
    send_frame(1'b0, 0, NPIX, 1'b1);
    model_latch();
    strobe_seen = 0; err_seen = 0;
    fill_const(24'h0000FF);
    send_frame(1'b0, 0, 20, 1'b1);
    total++; if (err_seen !== 1) begin bad++; $display("[TB] FAIL short_err got=%0d want=1", err_seen); end
    total++; if (strobe_seen !== 0) begin bad++; $display("[TB] FAIL short_strobe got=%0d want=0", strobe_seen); end
    total++; if (dut_res() !== model_res()) begin bad++; $display("[TB] FAIL short_held got=%h want=%h", dut_res(), model_res()); end
    strobe_seen = 0; err_seen = 0;
    fill_const(GREY);
    frame_pix[1*W + 3] = 24'h0000FF;
    frame_pix[1*W + 4] = 24'h0000FF;
    frame_pix[2*W + 3] = 24'h0000FF;
    send_frame(1'b0, 30, NPIX, 1'b1);
    model_latch();
    total++; if (strobe_seen !== 1 || err_seen !== 0) begin bad++; $display("[TB] FAIL short_recover strobe=%0d err=%0d want 1/0", strobe_seen, err_seen); end
    total++; if (dut_res() !== model_res()) begin bad++; $display("[TB] FAIL short_recover_res got=%h want=%h", dut_res(), model_res()); end
  endtask

  task automatic test_ctrl_packet();
    logic [23:0] d [0:3];
    logic [23:0] o [0:3];
    logic [31:0] r;
    strobe_seen = 0; err_seen = 0;
    overlay_en = 1'b1;
    d[0] = 24'hABCDEF;
    for (int i = 1; i < 4; i++) begin r = $urandom; d[i] = r[23:0]; end
    drive_beat(d[0], 1'b1, 1'b0, o[0]);
    total++; if ({source_valid, source_sop, source_eop} !== 3'b110) begin
      bad++; $display("[TB] FAIL ctrl_flags got=%b want=110", {source_valid, source_sop, source_eop}); end
    for (int i = 1; i < 4; i++) drive_beat(d[i], 1'b0, i == 3, o[i]);
    idle_cycles(1);
    for (int i = 0; i < 4; i++) begin
      total++; if (o[i] !== d[i]) begin bad++; $display("[TB] FAIL ctrl_pass[%0d] got=%h want=%h", i, o[i], d[i]); end
    end
    total++; if (strobe_seen !== 0 || err_seen !== 0) begin bad++; $display("[TB] FAIL ctrl_pulses strobe=%0d err=%0d want 0/0", strobe_seen, err_seen); end
    fill_const(GREY);
    frame_pix[0] = 24'h0000FF;
    frame_pix[NPIX-1] = 24'h0000FF;
    model_expect(1'b1);
    send_frame(1'b1, 0, NPIX, 1'b1);
    for (int i = 0; i < NPIX; i++) begin
      total++; if (obs[i] !== exp_px[i]) begin bad++; $display("[TB] FAIL ctrl_frame_px[%0d] got=%h want=%h", i, obs[i], exp_px[i]); end
    end
    total++; if (dut_res() !== {12'd0, 12'd7, 12'd0, 12'd3, 21'd2, 1'b1}) begin
      bad++; $display("[TB] FAIL ctrl_frame got=%h want=%h", dut_res(), {12'd0, 12'd7, 12'd0, 12'd3, 21'd2, 1'b1}); end
    model_latch();
  endtask

  task automatic test_drain();
    strobe_seen = 0; err_seen = 0;
    fill_random(40);
    send_frame(1'b0, 0, NPIX + 3, 1'b1);
    total++; if (err_seen !== 1 || strobe_seen !== 0) begin bad++; $display("[TB] FAIL drain_pulses err=%0d strobe=%0d want 1/0", err_seen, strobe_seen); end
    total++; if (dut_res() !== model_res()) begin bad++; $display("[TB] FAIL drain_held got=%h want=%h", dut_res(), model_res()); end
    strobe_seen = 0; err_seen = 0;
    fill_random(40);
    send_frame(1'b0, 0, 5, 1'b0);
    fill_random(25);
    model_expect(1'b1);
    send_frame(1'b1, 0, NPIX, 1'b1);
    model_latch();
    total++; if (err_seen !== 1 || strobe_seen !== 1) begin bad++; $display("[TB] FAIL resop_pulses err=%0d strobe=%0d want 1/1", err_seen, strobe_seen); end
    total++; if (dut_res() !== model_res()) begin bad++; $display("[TB] FAIL resop_res got=%h want=%h", dut_res(), model_res()); end
    for (int i = 0; i < NPIX; i++) begin
      total++; if (obs[i] !== exp_px[i]) begin bad++; $display("[TB] FAIL resop_px[%0d] got=%h want=%h", i, obs[i], exp_px[i]); end
    end
  endtask

  task automatic test_ready_gaps();
    logic r;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      r = 1'($urandom_range(1));
      source_ready = r;
      #1;
      total++; if (sink_ready !== r) begin bad++; $display("[TB] FAIL ready[%0d] got=%b want=%b", i, sink_ready, r); end
    end
    source_ready = 1'b1;
    strobe_seen = 0; err_seen = 0;
    fill_random(20);
    send_frame(1'b0, 60, NPIX, 1'b1);
    model_latch();
    total++; if (strobe_seen !== 1) begin bad++; $display("[TB] FAIL gaps_strobe got=%0d want=1", strobe_seen); end
    total++; if (dut_res() !== model_res()) begin bad++; $display("[TB] FAIL gaps_res got=%h want=%h", dut_res(), model_res()); end
  endtask

  task automatic test_random_frames();
    bit en;
    for (int f = 0; f < 8; f++) begin
      strobe_seen = 0; err_seen = 0;
      en = 1'($urandom_range(1));
      fill_random(int'($urandom_range(5, 30)));
      model_expect(en);
      send_frame(en, 25, NPIX, 1'b1);
      model_latch();
      total++; if (strobe_seen !== 1 || err_seen !== 0) begin bad++; $display("[TB] FAIL rnd%0d_pulses strobe=%0d err=%0d want 1/0", f, strobe_seen, err_seen); end
      total++; if (dut_res() !== model_res()) begin bad++; $display("[TB] FAIL rnd%0d_res got=%h want=%h", f, dut_res(), model_res()); end
      for (int i = 0; i < NPIX; i++) begin
        total++; if (obs[i] !== exp_px[i]) begin bad++; $display("[TB] FAIL rnd%0d_px[%0d] got=%h want=%h", f, i, obs[i], exp_px[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_red_box();
    test_overlay();
    test_threshold_edges();
    test_short_frame();
    test_ctrl_packet();
    test_drain();
    test_ready_gaps();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
